// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter and its round-robin picker.
package mul_share_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        CLEAR = 3'd2,
        BUSY  = 3'd3,
        RESP  = 3'd4
    } state_e;

    localparam int DEF_WIDTH   = 64;
    localparam int DEF_TIMEOUT = 255;

    // Increment an index modulo n by explicit compare, so non-power-of-two n wraps correctly.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    winner_o,
    output logic             any_req_o
);

    logic found_s;
    int   idx_s;

    // Scan N_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        winner_o = '0;
        found_s  = 1'b0;
        idx_s    = int'(ptr_i);
        for (int k = 0; k < N_REQ; k++) begin
            if (!found_s && req_i[idx_s]) begin
                winner_o = IW'(idx_s);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
            idx_s = wrap_inc(idx_s, N_REQ);
        end
        any_req_o = found_s;
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one multiplier core among N_REQ requesters.
// Handshake and core-control outputs are registered from the next state so they line up with it.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_multiplier,
    input  logic [N_REQ*WIDTH-1:0] req_multiplicand,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]     rsp_result,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [WIDTH-1:0]       mul_multiplier,
    output logic [WIDTH-1:0]       mul_multiplicand,
    output logic                   mul_op_start,
    output logic                   mul_op_clear,
    input  logic                   mul_op_done,
    input  logic [2*WIDTH-1:0]     mul_result
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_q, win_d;
    logic [IW-1:0]      pick_s;
    logic               any_req_s;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               err_q, err_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic [N_REQ-1:0]   rspv_q, rspv_d;
    logic               start_q, start_d;
    logic               clear_q, clear_d;
    logic               busy_q, busy_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .winner_o  (pick_s),
        .any_req_o (any_req_s)
    );

    // Next-state logic plus lookahead for the registered outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d = GRANT;
                    win_d   = pick_s;
                    a_d     = req_multiplier[int'(pick_s)*WIDTH +: WIDTH];
                    b_d     = req_multiplicand[int'(pick_s)*WIDTH +: WIDTH];
                    ptr_d   = IW'(wrap_inc(int'(pick_s), N_REQ));
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: state_d = CLEAR;
            CLEAR: begin
                state_d = BUSY;
                cnt_d   = '0;
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                // Done takes precedence over a timeout landing in the same cycle.
                if (mul_op_done) begin
                    res_d   = mul_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = BUSY;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == GRANT) ? (N_REQ'(1) << win_d) : '0;
        rspv_d  = (state_d == RESP)  ? (N_REQ'(1) << win_d) : '0;
        start_d = (state_d == BUSY);
        clear_d = (state_d == CLEAR) || (state_d == RESP);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset does not pulse the core clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= '0;
            rspv_q  <= '0;
            start_q <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            rspv_q  <= rspv_d;
            start_q <= start_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready        = ready_q;
    assign rsp_valid        = rspv_q;
    assign rsp_result       = res_q;
    assign rsp_err          = err_q;
    assign busy             = busy_q;
    assign mul_multiplier   = a_q;
    assign mul_multiplicand = b_q;
    assign mul_op_start     = start_q;
    assign mul_op_clear     = clear_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level round-robin model with a simple core model.
module tb_mul_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int TO = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_multiplier;
    logic [N*W-1:0]   req_multiplicand;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_result;
    logic             rsp_err;
    logic             busy;
    logic [W-1:0]     mul_multiplier;
    logic [W-1:0]     mul_multiplicand;
    logic             mul_op_start;
    logic             mul_op_clear;
    logic             mul_op_done;
    logic [2*W-1:0]   mul_result;

    int checks   = 0;
    int failures = 0;

    // Core model: done in the core_d-th start cycle after a clear; never if core_en is 0.
    int core_cnt = 0;
    int core_d   = 1;
    bit core_en  = 1'b0;

    typedef struct {
        int           idx;
        logic [63:0]  a;
        logic [63:0]  b;
        int           d;
        logic [127:0] res;
        logic         err;
    } vec_t;

    vec_t vecs [6];

    mul_share_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_multiplier   (req_multiplier),
        .req_multiplicand (req_multiplicand),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_result       (rsp_result),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_op_start     (mul_op_start),
        .mul_op_clear     (mul_op_clear),
        .mul_op_done      (mul_op_done),
        .mul_result       (mul_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_op_clear) core_cnt <= 0;
        else if (mul_op_start) core_cnt <= core_cnt + 1;
    end

    assign mul_op_done = core_en && mul_op_start && (core_cnt == core_d - 1);
    assign mul_result  = {64'd0, mul_multiplier} * {64'd0, mul_multiplicand};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b);
        req_multiplier[i*W +: W]   = a;
        req_multiplicand[i*W +: W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"}, req_ready, 128'd0);
        check({tag, " rsp_valid"}, rsp_valid, 128'd0);
        check({tag, " result"}, rsp_result, 128'd0);
        check({tag, " err"}, rsp_err, 128'd0);
        check({tag, " busy"}, busy, 128'd0);
        check({tag, " mul_a"}, mul_multiplier, 128'd0);
        check({tag, " mul_b"}, mul_multiplicand, 128'd0);
        check({tag, " start"}, mul_op_start, 128'd0);
        check({tag, " clear"}, mul_op_clear, 128'd0);
    endtask

    // Called in an IDLE cycle with requests already driven; follows one operation to completion.
    task automatic do_op(input string tag, input int win, input logic [127:0] exp_res,
                         input logic exp_err, input int exp_d, input bit hold);
        int t = 0;
        int busy_cyc = 0;
        int extra_ready = 0;
        while (req_ready == '0 && t < 8) begin
            tick();
            t++;
        end
        check({tag, " grant"}, req_ready, 128'd1 << win);
        if (!hold) req_valid[win] = 1'b0;
        t = 0;
        while (rsp_valid == '0 && t < TO + 8) begin
            tick();
            t++;
            if (mul_op_start) busy_cyc++;
            if (req_ready != '0) extra_ready++;
        end
        check({tag, " rsp_valid"}, rsp_valid, 128'd1 << win);
        check({tag, " result"}, rsp_result, exp_res);
        check({tag, " err"}, rsp_err, exp_err);
        check({tag, " clear_at_rsp"}, mul_op_clear, 128'd1);
        check({tag, " start_at_rsp"}, mul_op_start, 128'd0);
        check({tag, " busy_cycles"}, busy_cyc, exp_d);
        check({tag, " latency"}, t + 2, 4 + exp_d);
        check({tag, " ready_once"}, extra_ready, 128'd0);
        tick();
        check({tag, " rsp_pulse"}, rsp_valid, 128'd0);
        check({tag, " idle_busy"}, busy, 128'd0);
    endtask

    task automatic run_vec(input int n);
        int d_exp;
        for (int i = 0; i < N; i++) set_ops(i, {$urandom, $urandom}, {$urandom, $urandom});
        set_ops(vecs[n].idx, vecs[n].a, vecs[n].b);
        core_en   = (vecs[n].d != 0);
        core_d    = vecs[n].d;
        d_exp     = (vecs[n].d != 0) ? vecs[n].d : TO;
        req_valid = 4'd1 << vecs[n].idx;
        do_op($sformatf("vec%0d", n), vecs[n].idx, vecs[n].res, vecs[n].err, d_exp, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fa [N];
        logic [63:0] fb [N];
        logic [N-1:0] pending;
        logic [63:0]  pa [N];
        logic [63:0]  pb [N];
        int           ptr;
        int           win;
        int           d;
        logic [N-1:0] seen_rsp;

        vecs[0] = '{2, 64'd5, 64'd7, 3, 128'd35, 1'b0};
        vecs[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0};
        vecs[2] = '{3, 64'h1_0000_0000, 64'h1_0000_0000, 1, 128'd1 << 64, 1'b0};
        vecs[3] = '{1, 64'd123456789, 64'd987654321, 0, 128'd0, 1'b1};
        vecs[4] = '{2, 64'hDEAD_BEEF, 64'd3, TO, 128'(64'hDEAD_BEEF) * 128'd3, 1'b0};
        vecs[5] = '{1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 5,
                    128'(64'h0123_4567_89AB_CDEF) * 128'(64'hFEDC_BA98_7654_3210), 1'b0};

        reset            = 1'b1;
        req_valid        = '0;
        req_multiplier   = '0;
        req_multiplicand = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_all_zero("idle");

        for (int n = 0; n < 6; n++) run_vec(n);

        // Fairness: all requesters held from reset.
        do_reset();
        for (int i = 0; i < N; i++) begin
            fa[i] = {$urandom, $urandom};
            fb[i] = {$urandom, $urandom};
            set_ops(i, fa[i], fb[i]);
        end
        core_en   = 1'b1;
        core_d    = 2;
        req_valid = '1;
        for (int k = 0; k < 6; k++)
            do_op($sformatf("fair%0d", k), k % N, 128'(fa[k % N]) * 128'(fb[k % N]), 1'b0, 2, 1'b1);
        req_valid = '0;

        // Reset during BUSY: pointer was advanced to 2 before the reset.
        do_reset();
        core_en   = 1'b0;
        set_ops(1, 64'd11, 64'd13);
        req_valid = 4'b0010;
        tick();
        check("mid grant", req_ready, 128'd2);
        req_valid = '0;
        tick();
        tick();
        tick();
        check("mid in_busy", mul_op_start, 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mid_reset");
        seen_rsp = '0;
        for (int k = 0; k < 15; k++) begin
            tick();
            seen_rsp = seen_rsp | rsp_valid;
        end
        check("mid no_rsp", seen_rsp, 128'd0);
        set_ops(0, 64'd21, 64'd2);
        set_ops(2, 64'd9, 64'd9);
        core_en   = 1'b1;
        core_d    = 2;
        req_valid = 4'b0101;
        do_op("post_reset", 0, 128'd42, 1'b0, 2, 1'b0);
        req_valid = '0;

        // Randomized traffic against a transaction-level round-robin model.
        do_reset();
        ptr     = 0;
        pending = '0;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
                    pa[i]      = {$urandom, $urandom};
                    pb[i]      = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
                    pending[i] = 1'b1;
                    set_ops(i, pa[i], pb[i]);
                end
            end
            if (pending == '0) begin
                win          = $urandom_range(0, N - 1);
                pa[win]      = {$urandom, $urandom};
                pb[win]      = {$urandom, $urandom};
                pending[win] = 1'b1;
                set_ops(win, pa[win], pb[win]);
            end
            req_valid = pending;
            win = -1;
            for (int k = 0; k < N; k++) begin
                if (win < 0 && pending[(ptr + k) % N]) win = (ptr + k) % N;
            end
            d       = $urandom_range(0, TO);
            core_en = (d != 0);
            core_d  = d;
            do_op($sformatf("rnd%0d", n), win,
                  (d != 0) ? 128'(pa[win]) * 128'(pb[win]) : 128'd0,
                  (d == 0), (d != 0) ? d : TO, 1'b0);
            pending[win] = 1'b0;
            ptr          = (win + 1) % N;
        end
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that lets N_REQ requesters share one 64x64 multiplier core. Typical requesters are multiple factorial cores or other accelerator engines.
- Accepts one operand pair at a time and drives the multiplier's start/clear/done protocol.
- Returns the 128-bit product to the winning requester.
- Aborts with an error if the multiplier does not complete within a watchdog limit.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 64, operand width; the product is 2*WIDTH
- TIMEOUT, 255, max cycles in BUSY before abort (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request; held high until accepted
- req_multiplier  in  N_REQ*WIDTH  packed operand A; slice i belongs to requester i
- req_multiplicand  in  N_REQ*WIDTH  packed operand B; slice i belongs to requester i
- req_ready  out  N_REQ  one-hot, 1-cycle accept pulse
- rsp_valid  out  N_REQ  one-hot, 1-cycle completion pulse
- rsp_result  out  2*WIDTH  product; valid while rsp_valid is non-zero
- rsp_err  out  1  high together with rsp_valid on timeout abort
- busy  out  1  high in every state except IDLE
- mul_multiplier  out  WIDTH  to the multiplier core
- mul_multiplicand  out  WIDTH  to the multiplier core
- mul_op_start  out  1  level start to the multiplier core
- mul_op_clear  out  1  clear to the multiplier core
- mul_op_done  in  1  done from the multiplier core
- mul_result  in  2*WIDTH  product from the multiplier core

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - Round-robin pointer = 0, so requester 0 has first priority.
  - Timeout counter = 0.
- Reset mid-operation:
  - Returns to IDLE on the next edge.
  - No rsp_valid is emitted.
  - mul_op_clear is NOT pulsed by reset; the multiplier core has its own reset.
- States: IDLE -> GRANT -> CLEAR -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from the pointer upward, wrapping modulo N_REQ. Go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle):
  - req_ready[winner] = 1.
  - Latch the winner's operand slices into mul_multiplier and mul_multiplicand.
  - Latch the winner index.
  - Pointer <= winner + 1, wrapping modulo N_REQ.
- CLEAR (1 cycle):
  - mul_op_clear = 1, mul_op_start = 0.
  - Timeout counter <= 0.
- BUSY:
  - mul_op_start = 1 (level). Operands stay stable.
  - Counter increments by 1 each cycle.
  - On mul_op_done = 1: capture mul_result into rsp_result, rsp_err <= 0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT: rsp_result <= 0, rsp_err <= 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins and rsp_err = 0.
- RESP (1 cycle):
  - rsp_valid[winner] = 1.
  - mul_op_clear = 1 and mul_op_start = 0, releasing the core.
  - Next state is IDLE. rsp_result and rsp_err hold until the next capture.
- Latency from request sampled in IDLE to rsp_valid: 4 + D cycles, where D is the number of BUSY cycles (D >= 1).
- Requests arriving during a non-IDLE state are not sampled until the next IDLE. A requester may drop req_valid before it is accepted; such a request is simply ignored.
- A requester may reassert req_valid in the cycle its rsp_valid pulses. It competes in the following IDLE, where round-robin grants any other pending requester first.
- Throughput: at most one operation in flight. Minimum 5 cycles per operation.
- Outputs are registered: req_ready, rsp_valid, mul_op_start, mul_op_clear.
- All indices are clog2(N_REQ) bits wide. Pointer wrap uses an explicit compare against N_REQ-1; it does not depend on power-of-two overflow.

Decomposition:
- Shared package contents:
  - State encoding constants: IDLE, GRANT, CLEAR, BUSY, RESP.
  - Default WIDTH.
  - Default TIMEOUT.
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector, pointer.
  - Outputs: winner index, any_req.
- Reuse rr_pick for other shared-resource arbiters.

Test Plan:
- Single request: requester 2 sends A=5, B=7; the core model asserts done after 3 BUSY cycles. Required: req_ready[2] pulses once, rsp_valid[2] pulses with rsp_result=35 and rsp_err=0, total latency 7 cycles.
- Fairness: all four requesters hold valid continuously from reset. Required: grant order 0,1,2,3,0,1; each rsp_valid is one-hot and matches the preceding grant.
- Wide product: A=B=64'hFFFF_FFFF_FFFF_FFFF. Required: rsp_result = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Timeout: the core never asserts done, TIMEOUT=10. Required: after 10 BUSY cycles, rsp_valid pulses with rsp_err=1, rsp_result=0, and mul_op_clear=1 in the same cycle.
- Done/timeout collision: done arrives exactly when the counter reaches TIMEOUT. Required: rsp_err=0 and the real product is returned.
- Reset mid-BUSY: assert reset for 1 cycle during BUSY. Required: next cycle busy=0, all outputs 0, no rsp_valid, and the next grant goes to requester 0.
